// File: rtl/aes_key_sched_seq.sv
// AES-128 sequential key schedule: emits the eleven round keys one per
// valid/ready handshake, walking forward from the cipher key or backward
// from the round-10 key.

// Byte S-box computed from GF(2^8) inversion plus the affine map.
// dec=0 gives the forward S-box, dec=1 the inverse S-box.
module aes_sbox_lut (
  input  logic       dec,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] s_inv;
  logic [7:0] t_aff;

  // forward: affine(inv(x)); inverse: inv(affine^-1(x))
  always_comb begin
    dout  = 8'h00;
    s_inv = gf_inv(din);
    t_aff = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
    if (dec)
      dout = gf_inv(t_aff);
    else
      dout = s_inv ^ rotl(s_inv, 1) ^ rotl(s_inv, 2) ^ rotl(s_inv, 3)
           ^ rotl(s_inv, 4) ^ 8'h63;
  end

endmodule

module aes_key_sched_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_i,
  input  logic         dec_i,
  input  logic         start_i,
  output logic [127:0] rk_o,
  output logic [3:0]   round_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  localparam int NUM_SBOX = 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nxt;
  logic [127:0] rk;
  logic [3:0]   round;
  logic [7:0]   rcon, rcon_nxt;
  logic         dec_q;
  logic         done;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw;
  logic [NUM_SBOX-1:0][7:0] sb_in, sb_out;
  logic [31:0]  t;
  logic [127:0] rk_nxt;
  logic         hs, last;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  // Reverse step needs SubWord of the already-recovered w3', so the one
  // S-box bank is shared by selecting its source word on direction.
  assign sw    = dec_q ? (w3 ^ w2) : w3;
  assign sb_in = {sw[23:0], sw[31:24]};
  assign t     = sb_out ^ {rcon, 24'h0};

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    aes_sbox_lut u_sbox (
      .dec  (1'b0),
      .din  (sb_in[g]),
      .dout (sb_out[g])
    );
  end

  assign hs   = (state == RUN) && rk_ready_i;
  assign last = dec_q ? (round == 4'd0) : (round == 4'd10);

  // next round key and rcon for the current direction
  always_comb begin
    rk_nxt   = rk;
    rcon_nxt = rcon;
    if (dec_q) begin
      rk_nxt[31:0]   = w3 ^ w2;
      rk_nxt[63:32]  = w2 ^ w1;
      rk_nxt[95:64]  = w1 ^ w0;
      rk_nxt[127:96] = w0 ^ t;
      rcon_nxt       = {1'b0, rcon[7:1]} ^ (rcon[0] ? 8'h8d : 8'h00);
    end else begin
      rk_nxt[127:96] = w0 ^ t;
      rk_nxt[95:64]  = w1 ^ w0 ^ t;
      rk_nxt[63:32]  = w2 ^ w1 ^ w0 ^ t;
      rk_nxt[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ t;
      rcon_nxt       = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: start only honoured in IDLE, leave after last handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i)     state_nxt = RUN;
      RUN:  if (hs && last)  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // key / round / rcon registers and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rk    <= '0;
      round <= 4'd0;
      rcon  <= 8'h01;
      dec_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start_i) begin
        rk    <= key_i;
        dec_q <= dec_i;
        round <= dec_i ? 4'd10 : 4'd0;
        rcon  <= dec_i ? 8'h36 : 8'h01;
      end else if (hs) begin
        if (last) begin
          done <= 1'b1;
        end else begin
          rk    <= rk_nxt;
          rcon  <= rcon_nxt;
          round <= dec_q ? round - 4'd1 : round + 4'd1;
        end
      end
    end
  end

  assign rk_o       = rk;
  assign round_o    = round;
  assign rk_valid_o = (state == RUN);
  assign busy_o     = (state == RUN);
  assign done_o     = done;

endmodule
